// File: rtl/sobel_gradient_pipe.sv
// sobel_gradient_pipe
//   Three-stage Sobel gradient pipeline over a 3x3 pixel window.
//   S1 forms the four weighted row/column sums, S2 the signed gx/gy
//   differences, S3 |gx|+|gy| saturated to the pixel range.
//   Every stage carries a valid bit and the whole pipe advances together
//   whenever the output register is empty or being drained.
//
// Parameters
//   PIXEL_W  unsigned pixel width (4..16)
//   MODE     0 = vertical gradient only, 1 = horizontal only, 2 = both
//   GRAD_W   derived signed gradient width, PIXEL_W+3
//
// Ports
//   clk        single clock, all state on the rising edge
//   reset      synchronous active-high reset
//   window     9 pixels, Pk at [k*PIXEL_W +: PIXEL_W], row-major, P0 top-left
//   in_valid   window is valid
//   in_ready   block accepts window (combinational pipeline advance)
//   gx, gy     signed horizontal / vertical gradients
//   mag        saturated |gx|+|gy|
//   out_valid  gx/gy/mag are valid
//   out_ready  sink accepts result
//   out_count  number of results handed off, wraps at 16 bits
//
// Optional feature (macro SOBEL_THRESH_EN)
//   thresh     edge threshold
//   edge_det   registered (mag >= thresh); named edge_det because "edge"
//              is a reserved word
module sobel_gradient_pipe #(
  parameter int unsigned PIXEL_W = 8,
  parameter int unsigned MODE    = 2,
  localparam int unsigned GRAD_W = PIXEL_W + 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [9*PIXEL_W-1:0]       window,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic signed [GRAD_W-1:0]   gx,
  output logic signed [GRAD_W-1:0]   gy,
  output logic [PIXEL_W-1:0]         mag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_count
`ifdef SOBEL_THRESH_EN
  ,
  input  logic [PIXEL_W-1:0]         thresh,
  output logic                       edge_det
`endif
);

  localparam int unsigned SUM_W = PIXEL_W + 2;

  logic adv;
  logic v1, v2, v3;

  logic [PIXEL_W-1:0] p [9];
  logic [SUM_W-1:0]   top_c, bot_c, lft_c, rgt_c;
  logic [SUM_W-1:0]   top_q, bot_q, lft_q, rgt_q;

  logic signed [GRAD_W-1:0] gx_c, gy_c;
  logic signed [GRAD_W-1:0] gx_q, gy_q;

  logic [GRAD_W-1:0]  ax_c, ay_c;
  logic [GRAD_W:0]    sum_c;
  logic [PIXEL_W-1:0] mag_c;

  assign adv       = out_ready || !out_valid;
  assign in_ready  = adv;
  assign out_valid = v3;

  // S1 combinational: weighted row and column sums
  always_comb begin
    for (int unsigned k = 0; k < 9; k++) begin
      p[k] = window[k*PIXEL_W +: PIXEL_W];
    end
    top_c = SUM_W'(p[0]) + (SUM_W'(p[1]) << 1) + SUM_W'(p[2]);
    bot_c = SUM_W'(p[6]) + (SUM_W'(p[7]) << 1) + SUM_W'(p[8]);
    lft_c = SUM_W'(p[0]) + (SUM_W'(p[3]) << 1) + SUM_W'(p[6]);
    rgt_c = SUM_W'(p[2]) + (SUM_W'(p[5]) << 1) + SUM_W'(p[8]);
  end

  // S2 combinational: signed differences, zero-extended sums so the
  // full +/-4*(2^PIXEL_W-1) range fits in GRAD_W
  always_comb begin
    gy_c = $signed({1'b0, top_q}) - $signed({1'b0, bot_q});
    gx_c = $signed({1'b0, rgt_q}) - $signed({1'b0, lft_q});
    if (MODE == 0) gx_c = '0;
    if (MODE == 1) gy_c = '0;
  end

  // S3 combinational: magnitudes taken as unsigned GRAD_W values, so
  // negating the most negative gradient cannot overflow
  always_comb begin
    ax_c  = gx_q[GRAD_W-1] ? GRAD_W'(-gx_q) : GRAD_W'(gx_q);
    ay_c  = gy_q[GRAD_W-1] ? GRAD_W'(-gy_q) : GRAD_W'(gy_q);
    sum_c = {1'b0, ax_c} + {1'b0, ay_c};
    mag_c = (|sum_c[GRAD_W:PIXEL_W]) ? '1 : sum_c[PIXEL_W-1:0];
  end

  // Datapath registers for S1/S2; only loaded by valid data so bubbles
  // leave them untouched
  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      top_q <= top_c;
      bot_q <= bot_c;
      lft_q <= lft_c;
      rgt_q <= rgt_c;
    end
    if (adv && v1) begin
      gx_q <= gx_c;
      gy_q <= gy_c;
    end
  end

  // Valid chain, S3 output registers and handoff counter
  always_ff @(posedge clk) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      gx        <= '0;
      gy        <= '0;
      mag       <= '0;
      out_count <= '0;
    end else begin
      if (adv) begin
        v1 <= in_valid;
        v2 <= v1;
        v3 <= v2;
        if (v2) begin
          gx  <= gx_q;
          gy  <= gy_q;
          mag <= mag_c;
        end
      end
      if (v3 && out_ready) begin
        out_count <= out_count + 16'd1;
      end
    end
  end

`ifdef SOBEL_THRESH_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_det <= 1'b0;
    end else if (adv && v2) begin
      edge_det <= (mag_c >= thresh);
    end
  end
`else
  // No threshold comparator in this build.
`endif

endmodule

// File: tb/tb_sobel_gradient_pipe.sv
module tb_sobel_gradient_pipe;

  localparam int PW   = 8;
  localparam int GW   = PW + 3;
  localparam int MAXV = 255;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [9*PW-1:0] window = '0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;

  logic in_ready, out_valid;
  logic signed [GW-1:0] gx, gy;
  logic [PW-1:0] mag;
  logic [15:0] out_count;

  logic in_ready_v, out_valid_v;
  logic signed [GW-1:0] gx_v, gy_v;
  logic [PW-1:0] mag_v;
  logic [15:0] out_count_v;

`ifdef SOBEL_THRESH_EN
  logic [PW-1:0] thresh = '0;
  logic edge_det, edge_det_v;
`endif

  sobel_gradient_pipe #(.PIXEL_W(PW), .MODE(2)) dut (
    .clk(clk), .reset(reset), .window(window), .in_valid(in_valid),
    .in_ready(in_ready), .gx(gx), .gy(gy), .mag(mag), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count)
`ifdef SOBEL_THRESH_EN
    , .thresh(thresh), .edge_det(edge_det)
`endif
  );

  sobel_gradient_pipe #(.PIXEL_W(PW), .MODE(0)) dut_v (
    .clk(clk), .reset(reset), .window(window), .in_valid(in_valid),
    .in_ready(in_ready_v), .gx(gx_v), .gy(gy_v), .mag(mag_v), .out_valid(out_valid_v),
    .out_ready(out_ready), .out_count(out_count_v)
`ifdef SOBEL_THRESH_EN
    , .thresh(thresh), .edge_det(edge_det_v)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int gx2, gy2, mag2, edge2;
    int gx0, gy0, mag0, edge0;
    int acc_cyc;
    bit lat_chk;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit lat_mode = 1'b0;
  logic [15:0] exp_count = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic int sat(input int a);
    return (a > MAXV) ? MAXV : a;
  endfunction

  // Reference: Sobel kernels applied directly to the nine pixels
  function automatic exp_t model(input logic [9*PW-1:0] w, input int th);
    exp_t e;
    int p[9];
    int sx, sy;
    for (int k = 0; k < 9; k++) p[k] = int'(w[k*PW +: PW]);
    sy = (p[0] + 2*p[1] + p[2]) - (p[6] + 2*p[7] + p[8]);
    sx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
    e.gx2 = sx;
    e.gy2 = sy;
    e.mag2 = sat(iabs(sx) + iabs(sy));
    e.edge2 = (e.mag2 >= th) ? 1 : 0;
    e.gx0 = 0;
    e.gy0 = sy;
    e.mag0 = sat(iabs(sy));
    e.edge0 = (e.mag0 >= th) ? 1 : 0;
    e.acc_cyc = 0;
    e.lat_chk = 1'b0;
    return e;
  endfunction

  function automatic logic [9*PW-1:0] pack9(input int p[9]);
    logic [9*PW-1:0] w;
    for (int k = 0; k < 9; k++) w[k*PW +: PW] = PW'(p[k]);
    return w;
  endfunction

  // Stimulus side of the scoreboard: expected result queued on accept
  always @(negedge clk) begin : accept_proc
    exp_t e;
    int th;
    if (reset) begin
      sb.delete();
    end else if (in_valid && in_ready) begin
`ifdef SOBEL_THRESH_EN
      th = int'(thresh);
`else
      th = 0;
`endif
      e = model(window, th);
      e.acc_cyc = cyc;
      e.lat_chk = lat_mode;
      sb.push_back(e);
    end
  end

  // Monitor side: checks handoffs, hold behaviour, counter and reset state
  bit rst_seen = 1'b0;
  bit hold_pend = 1'b0;
  int h_gx, h_gy, h_mag, h_mag_v;

  always @(negedge clk) begin : monitor_proc
    exp_t e;
    if (reset) begin
      rst_seen = 1'b1;
      hold_pend = 1'b0;
    end else begin
      if (rst_seen) begin
        chk("post_reset_out_valid", int'(out_valid), 0);
        chk("post_reset_out_count", int'(out_count), 0);
        chk("post_reset_in_ready", int'(in_ready), 1);
        chk("post_reset_gx", int'(gx), 0);
        chk("post_reset_mag", int'(mag), 0);
`ifdef SOBEL_THRESH_EN
        chk("post_reset_edge", int'(edge_det), 0);
`endif
        exp_count = '0;
        rst_seen = 1'b0;
      end
      if (hold_pend) begin
        chk("hold_out_valid", int'(out_valid), 1);
        chk("hold_gx", int'(gx), h_gx);
        chk("hold_gy", int'(gy), h_gy);
        chk("hold_mag", int'(mag), h_mag);
        chk("hold_mag_v", int'(mag_v), h_mag_v);
      end
      chk("out_count", int'(out_count), int'(exp_count));
      chk("out_count_v", int'(out_count_v), int'(exp_count));
      chk("lockstep_valid", int'(out_valid_v), int'(out_valid));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("gx", int'(gx), e.gx2);
          chk("gy", int'(gy), e.gy2);
          chk("mag", int'(mag), e.mag2);
          chk("gx_mode0", int'(gx_v), e.gx0);
          chk("gy_mode0", int'(gy_v), e.gy0);
          chk("mag_mode0", int'(mag_v), e.mag0);
`ifdef SOBEL_THRESH_EN
          chk("edge", int'(edge_det), e.edge2);
          chk("edge_mode0", int'(edge_det_v), e.edge0);
`endif
          if (e.lat_chk) chk("latency", cyc - e.acc_cyc, 3);
        end
        exp_count = exp_count + 16'd1;
      end
      hold_pend = out_valid && !out_ready;
      h_gx = int'(gx);
      h_gy = int'(gy);
      h_mag = int'(mag);
      h_mag_v = int'(mag_v);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [9*PW-1:0] w);
    bit ok = 1'b0;
    window = w;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready && !reset) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send_timeout", int'(ok), 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_timeout", int'(ok), 1);
    step();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  function automatic int rand_pix();
    if ($urandom_range(0, 2) == 0) return ($urandom_range(0, 1) == 1) ? MAXV : 0;
    return int'($urandom_range(0, MAXV));
  endfunction

  function automatic logic [9*PW-1:0] rand_win();
    int p[9];
    for (int k = 0; k < 9; k++) p[k] = rand_pix();
    return pack9(p);
  endfunction

  initial begin
    int p[9];
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Directed windows with out_ready held high: latency is exactly 3
    lat_mode = 1'b1;
    out_ready = 1'b1;
    p = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
    send(pack9(p));
    drain();
    p = '{255, 255, 255, 0, 0, 0, 0, 0, 0};
    send(pack9(p));
    drain();
    p = '{0, 0, 0, 0, 0, 0, 255, 255, 255};
    send(pack9(p));
    drain();
    p = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
    send(pack9(p));
    drain();
    // Back-to-back throughput
    for (int i = 0; i < 6; i++) send(rand_win());
    drain();
`ifdef SOBEL_THRESH_EN
    thresh = 8'd50;
    p = '{0, 40, 0, 0, 0, 0, 0, 0, 0};
    send(pack9(p));
    drain();
    thresh = 8'd81;
    send(pack9(p));
    drain();
`endif
    lat_mode = 1'b0;

    // Three accepted, then the sink stalls for five cycles
    pulse_reset();
    for (int i = 0; i < 3; i++) send(rand_win());
    out_ready = 1'b0;
    repeat (5) step();
    @(negedge clk);
    chk("stall_in_ready", int'(in_ready), 0);
    chk("stall_out_valid", int'(out_valid), 1);
    step();
    drain();
    chk("stall_count", int'(out_count), 3);

    // Reset with two windows in flight
    send(rand_win());
    send(rand_win());
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (6) step();
    @(negedge clk);
    chk("flush_out_valid", int'(out_valid), 0);
    chk("flush_out_count", int'(out_count), 0);
    step();

    // Randomized traffic with random backpressure
`ifdef SOBEL_THRESH_EN
    thresh = PW'($urandom_range(0, MAXV));
`endif
    for (int i = 0; i < 500; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      window = rand_win();
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/sobel_gradient_pipe.md
SOBEL_GRADIENT_PIPE -- requirements
Module: sobel_gradient_pipe

Interface
REQ-001 SHALL have parameter PIXEL_W, default 8, unsigned pixel width; legal range 4..16.
REQ-002 SHALL have parameter MODE, default 2; 0 = vertical only, 1 = horizontal only, 2 = both.
REQ-003 SHALL derive localparam GRAD_W = PIXEL_W+3, the signed gradient width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port window, input, 9*PIXEL_W; pixel Pk at bits [k*PIXEL_W +: PIXEL_W], row-major, P0 top-left, P8 bottom-right.
REQ-007 SHALL have port in_valid, input, 1; window is valid.
REQ-008 SHALL have port in_ready, output, 1; block accepts window.
REQ-009 SHALL have port gx, output, GRAD_W, signed horizontal gradient.
REQ-010 SHALL have port gy, output, GRAD_W, signed vertical gradient.
REQ-011 SHALL have port mag, output, PIXEL_W, saturated magnitude.
REQ-012 SHALL have port out_valid, output, 1; gx/gy/mag are valid.
REQ-013 SHALL have port out_ready, input, 1; sink accepts result.
REQ-014 SHALL have port out_count, output, 16, number of accepted results.

Function
REQ-015 SHALL compute gy = (P0+2*P1+P2) - (P6+2*P7+P8) at full precision in GRAD_W bits.
REQ-016 SHALL compute gx = (P2+2*P5+P8) - (P0+2*P3+P6) at full precision in GRAD_W bits.
REQ-017 SHALL force gx to 0 when MODE=0 and gy to 0 when MODE=1.
REQ-018 SHALL compute mag = |gx|+|gy| in GRAD_W+1 bits and saturate it to 2^PIXEL_W-1.
REQ-019 SHALL take the absolute value of -4*(2^PIXEL_W-1) exactly, with no overflow.
REQ-020 SHALL use a 3-stage pipeline: S1 row/column sums, S2 signed differences, S3 abs, add and saturate.
REQ-021 SHALL present a result 3 cycles after acceptance when out_ready is held high.
REQ-022 SHALL define an accept as a cycle with in_valid && in_ready high.
REQ-023 SHALL define a handoff as a cycle with out_valid && out_ready high.
REQ-024 SHALL compute the pipeline advance enable as adv = out_ready || !out_valid.
REQ-025 SHALL advance all stages, bubbles included, only when adv is high.
REQ-026 SHALL drive in_ready = adv, combinationally.
REQ-027 SHALL carry a valid bit per stage, so an empty slot advances as a bubble.
REQ-028 SHALL keep gx, gy, mag and out_valid stable while out_valid=1 and out_ready=0.
REQ-029 SHALL increment out_count on each handoff and wrap from 0xFFFF to 0.
REQ-030 SHALL ignore window contents when in_valid=0.
REQ-031 SHALL sustain one result per cycle with in_valid=1 and out_ready=1, with no bubbles.

Reset
REQ-032 SHALL clear all stage valid bits, gx, gy, mag and out_count to 0 on reset, discarding in-flight data.
REQ-033 SHALL hold in_ready=1 on the first cycle after reset.
REQ-034 SHALL give reset priority over a simultaneous accept or handoff.

Configuration
REQ-035 SHALL add, when SOBEL_THRESH_EN is defined, input thresh[PIXEL_W] and output edge[1], with edge = (mag >= thresh) registered in S3 and reset to 0.
REQ-036 SHALL omit the thresh and edge ports and their logic when SOBEL_THRESH_EN is undefined.

Verification (PIXEL_W=8, MODE=2)
REQ-037 SHALL cover: all pixels 100 -> gx=0, gy=0, mag=0 three cycles after accept.
REQ-038 SHALL cover: top row 255, other rows 0 -> gy=+1020, gx=0, mag=255 (saturated); bottom row 255 instead -> gy=-1020.
REQ-039 SHALL cover: left column 0, right column 255, centre 0 -> gx=+1020, gy=0, mag=255; MODE=0 rerun -> gx=0.
REQ-040 SHALL cover: 3 windows accepted, then out_ready=0 for 5 cycles -> in_ready=0, outputs held, all 3 delivered in order, out_count=3.
REQ-041 SHALL cover: reset asserted with 2 items in flight -> out_valid=0 and out_count=0 the next cycle, no stale result emitted.
REQ-042 SHALL cover, with SOBEL_THRESH_EN: thresh=50, P1=40, others 0 -> gy=80, mag=80, edge=1; thresh=81 -> edge=0.
